// File: rtl/rat_table_pkg.sv
// Shared types for the register alias table.
// PREG_IDX_W     : physical register tag width (64 physical registers)
// ARCH_IDX_W     : architectural register index width (32 RAT rows)
// RAT_READ_INPACKET / RAT_WRITE_INPACKET / RAT_READ_OUTPACKET / CDB_PACKET :
//                  per-port request/response records used on the rat_table ports
package rat_table_pkg;

  localparam int unsigned PREG_IDX_W    = 6;
  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned ARCH_IDX_W    = $clog2(NUM_ARCH_REGS);

  typedef logic [PREG_IDX_W-1:0] preg_idx_t;
  typedef logic [ARCH_IDX_W-1:0] arch_idx_t;

  typedef struct packed {
    logic      read_en;
    arch_idx_t addr;
  } RAT_READ_INPACKET;

  typedef struct packed {
    logic      write_en;
    arch_idx_t addr;
    preg_idx_t tag;
  } RAT_WRITE_INPACKET;

  typedef struct packed {
    preg_idx_t tag;
    logic      preg_ready;
  } RAT_READ_OUTPACKET;

  typedef struct packed {
    logic      cdb_valid;
    preg_idx_t tag;
  } CDB_PACKET;

endpackage

// File: rtl/rat_fwd_mux.sv
// Per-read-port output mux with intra-bundle forwarding.
// rd          : read request of this port
// table_tag   : registered table tag at rd.addr
// table_ready : registered table ready bit at rd.addr
// wr          : all write requests of the current bundle
// out         : tag / preg_ready presented on the read port
// Only writes from requests older than REQ_IDX may forward; the youngest
// matching older write wins and its result is never ready yet.
module rat_fwd_mux
  import rat_table_pkg::*;
#(
  parameter int unsigned numOfRequests = 2,
  parameter int unsigned REQ_IDX       = 0
) (
  input  RAT_READ_INPACKET  rd,
  input  preg_idx_t         table_tag,
  input  logic              table_ready,
  input  RAT_WRITE_INPACKET wr [numOfRequests],
  output RAT_READ_OUTPACKET out
);

  // Bit w set when write w is older than this port's request.
  localparam logic [numOfRequests-1:0] OLDER = numOfRequests'((1 << REQ_IDX) - 1);

  always_comb begin
    out = '0;
    if (rd.read_en) begin
      out.tag        = table_tag;
      out.preg_ready = table_ready;
      for (int unsigned w = 0; w < numOfRequests; w++) begin
        if (OLDER[w] && wr[w].write_en && (wr[w].addr == rd.addr)) begin
          out.tag        = wr[w].tag;
          out.preg_ready = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rat_table.sv
// Register alias table: maps architectural registers to physical tags and
// tracks whether each mapped physical register has been produced.
// clock            : rising-edge clock
// reset            : asynchronous active-low reset (entry i -> tag i, ready)
// cdb_packet       : completion broadcasts, one per lane
// rat_read_packet  : 2 read ports per request (ports 2r, 2r+1 for request r)
// rat_write_packet : one rename write per request
// rat_packet       : combinational read results (tag, preg_ready)
module rat_table
  import rat_table_pkg::*;
#(
  parameter int unsigned numOfEntries  = 32,
  parameter int unsigned numOfRequests = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  CDB_PACKET         cdb_packet       [numOfRequests],
  input  RAT_READ_INPACKET  rat_read_packet  [2*numOfRequests],
  input  RAT_WRITE_INPACKET rat_write_packet [numOfRequests],
  output RAT_READ_OUTPACKET rat_packet       [2*numOfRequests]
);

  localparam int unsigned NUM_PORTS = 2 * numOfRequests;

  preg_idx_t                tag_q   [numOfEntries];
  preg_idx_t                tag_d   [numOfEntries];
  logic [numOfEntries-1:0]  ready_q;
  logic [numOfEntries-1:0]  ready_d;

  preg_idx_t                rd_tag  [NUM_PORTS];
  logic [NUM_PORTS-1:0]     rd_ready;

  // CDB wakeup first, then writes in ascending order so that a write beats
  // a same-cycle wakeup and the highest-indexed write to a row wins.
  always_comb begin
    tag_d   = tag_q;
    ready_d = ready_q;
    for (int unsigned e = 0; e < numOfEntries; e++) begin
      for (int unsigned l = 0; l < numOfRequests; l++) begin
        if (cdb_packet[l].cdb_valid && (cdb_packet[l].tag == tag_q[e])) begin
          ready_d[e] = 1'b1;
        end
      end
      for (int unsigned w = 0; w < numOfRequests; w++) begin
        if (rat_write_packet[w].write_en && (rat_write_packet[w].addr == ARCH_IDX_W'(e))) begin
          tag_d[e]   = rat_write_packet[w].tag;
          ready_d[e] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned e = 0; e < numOfEntries; e++) begin
        tag_q[e] <= PREG_IDX_W'(e);
      end
      ready_q <= '1;
    end else begin
      tag_q   <= tag_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    rd_ready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rd_tag[p]   = tag_q[rat_read_packet[p].addr];
      rd_ready[p] = ready_q[rat_read_packet[p].addr];
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rat_fwd_mux #(
      .numOfRequests (numOfRequests),
      .REQ_IDX       (p / 2)
    ) u_fwd (
      .rd          (rat_read_packet[p]),
      .table_tag   (rd_tag[p]),
      .table_ready (rd_ready[p]),
      .wr          (rat_write_packet),
      .out         (rat_packet[p])
    );
  end

endmodule

// File: tb/tb_rat_table.sv
module tb_rat_table;
  import rat_table_pkg::*;

  localparam int unsigned NE = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned NP = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  CDB_PACKET         cdb [NR];
  RAT_READ_INPACKET  rd  [NP];
  RAT_WRITE_INPACKET wr  [NR];
  RAT_READ_OUTPACKET rp  [NP];

  rat_table #(.numOfEntries(NE), .numOfRequests(NR)) dut (
    .clock            (clock),
    .reset            (reset),
    .cdb_packet       (cdb),
    .rat_read_packet  (rd),
    .rat_write_packet (wr),
    .rat_packet       (rp)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural -> physical map plus ready flags.
  int unsigned m_tag [NE];
  bit          m_rdy [NE];

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) begin
      m_tag[i] = i;
      m_rdy[i] = 1'b1;
    end
  endfunction

  function automatic void model_edge();
    bit done [64];
    for (int t = 0; t < 64; t++) done[t] = 1'b0;
    for (int l = 0; l < NR; l++)
      if (cdb[l].cdb_valid) done[cdb[l].tag] = 1'b1;
    for (int e = 0; e < NE; e++)
      if (done[m_tag[e]]) m_rdy[e] = 1'b1;
    for (int w = 0; w < NR; w++)
      if (wr[w].write_en) begin
        m_tag[wr[w].addr] = wr[w].tag;
        m_rdy[wr[w].addr] = 1'b0;
      end
  endfunction

  function automatic void predict(input int p, output int unsigned t, output bit r);
    t = 0;
    r = 1'b0;
    if (rd[p].read_en) begin
      t = m_tag[rd[p].addr];
      r = m_rdy[rd[p].addr];
      for (int w = p / 2 - 1; w >= 0; w--) begin
        if (wr[w].write_en && wr[w].addr == rd[p].addr) begin
          t = wr[w].tag;
          r = 1'b0;
          break;
        end
      end
    end
  endfunction

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset) model_reset();
    else        model_edge();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NP; p++) rd[p] = '0;
    for (int w = 0; w < NR; w++) begin
      wr[w]  = '0;
      cdb[w] = '0;
    end
  endtask

  typedef struct packed {
    logic [3:0]      ren;
    logic [3:0][4:0] raddr;
    logic [1:0]      wen;
    logic [1:0][4:0] waddr;
    logic [1:0][5:0] wtag;
    logic [1:0]      cv;
    logic [1:0][5:0] ctag;
    logic [3:0][5:0] etag;
    logic [3:0]      erdy;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] ren, input logic [3:0][4:0] raddr,
                               input logic [1:0] wen, input logic [1:0][4:0] waddr,
                               input logic [1:0][5:0] wtag, input logic [1:0] cv,
                               input logic [1:0][5:0] ctag, input logic [3:0][5:0] etag,
                               input logic [3:0] erdy);
    vec_t v;
    v.ren = ren; v.raddr = raddr; v.wen = wen; v.waddr = waddr; v.wtag = wtag;
    v.cv = cv; v.ctag = ctag; v.etag = etag; v.erdy = erdy;
    return v;
  endfunction

  vec_t vt [12];

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    for (int p = 0; p < NP; p++) begin
      rd[p].read_en = v.ren[p];
      rd[p].addr    = v.raddr[p];
    end
    for (int w = 0; w < NR; w++) begin
      wr[w].write_en  = v.wen[w];
      wr[w].addr      = v.waddr[w];
      wr[w].tag       = v.wtag[w];
      cdb[w].cdb_valid = v.cv[w];
      cdb[w].tag       = v.ctag[w];
    end
    #1;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("vec%0d port%0d tag", i, p), rp[p].tag, v.etag[p]);
      check($sformatf("vec%0d port%0d ready", i, p), rp[p].preg_ready, v.erdy[p]);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned et;
    bit er;

    // Directed vectors: reads listed port3..port0, writes/CDB lane1..lane0.
    vt[0]  = mkv(4'hF, {5'd12,5'd7,5'd5,5'd0}, 2'b00, '0, '0, 2'b00, '0,
                 {6'd12,6'd7,6'd5,6'd0}, 4'b1111);
    vt[1]  = mkv(4'hF, {5'd12,5'd7,5'd5,5'd0}, 2'b01, {5'd0,5'd0}, {6'd0,6'd4}, 2'b00, '0,
                 {6'd12,6'd7,6'd5,6'd0}, 4'b1111);
    vt[2]  = mkv(4'hF, {5'd12,5'd7,5'd5,5'd0}, 2'b10, {5'd12,5'd0}, {6'd31,6'd0}, 2'b00, '0,
                 {6'd12,6'd7,6'd5,6'd4}, 4'b1110);
    vt[3]  = mkv(4'hF, {5'd12,5'd7,5'd5,5'd0}, 2'b00, '0, '0, 2'b11, {6'd31,6'd4},
                 {6'd31,6'd7,6'd5,6'd4}, 4'b0110);
    vt[4]  = mkv(4'hF, {5'd12,5'd7,5'd5,5'd0}, 2'b00, '0, '0, 2'b00, '0,
                 {6'd31,6'd7,6'd5,6'd4}, 4'b1111);
    vt[5]  = mkv(4'hF, {5'd3,5'd0,5'd1,5'd0}, 2'b11, {5'd0,5'd0}, {6'd13,6'd12}, 2'b00, '0,
                 {6'd3,6'd12,6'd1,6'd0}, 4'b1011);
    vt[6]  = mkv(4'hF, {5'd3,5'd0,5'd1,5'd0}, 2'b00, '0, '0, 2'b00, '0,
                 {6'd3,6'd13,6'd1,6'd13}, 4'b1010);
    vt[7]  = mkv(4'hF, {5'd5,5'd5,5'd5,5'd5}, 2'b01, {5'd0,5'd5}, {6'd0,6'd20}, 2'b01, {6'd0,6'd5},
                 {6'd20,6'd20,6'd5,6'd5}, 4'b0011);
    vt[8]  = mkv(4'hF, {5'd5,5'd5,5'd5,5'd5}, 2'b00, '0, '0, 2'b00, '0,
                 {6'd20,6'd20,6'd20,6'd20}, 4'b0000);
    vt[9]  = mkv(4'b0101, {5'd3,5'd3,5'd3,5'd3}, 2'b01, {5'd0,5'd3}, {6'd0,6'd9}, 2'b00, '0,
                 {6'd0,6'd9,6'd0,6'd3}, 4'b0001);
    vt[10] = mkv(4'hF, {5'd3,5'd3,5'd3,5'd3}, 2'b00, '0, '0, 2'b01, {6'd0,6'd9},
                 {6'd9,6'd9,6'd9,6'd9}, 4'b0000);
    vt[11] = mkv(4'hF, {5'd3,5'd3,5'd3,5'd3}, 2'b00, '0, '0, 2'b00, '0,
                 {6'd9,6'd9,6'd9,6'd9}, 4'b1111);

    idle_inputs();
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i <= 4; i++) run_vec(i);

    // Asynchronous reset in the middle of a cycle discards mappings at once.
    idle_inputs();
    #2;
    rd[0] = '{read_en: 1'b1, addr: 5'd0};
    rd[1] = '{read_en: 1'b1, addr: 5'd12};
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst port0 tag", rp[0].tag, 0);
    check("async_rst port0 ready", rp[0].preg_ready, 1);
    check("async_rst port1 tag", rp[1].tag, 12);
    check("async_rst port1 ready", rp[1].preg_ready, 1);

    // Reset held across an edge dominates writes and CDB.
    wr[0]  = '{write_en: 1'b1, addr: 5'd0,  tag: 6'd40};
    wr[1]  = '{write_en: 1'b1, addr: 5'd12, tag: 6'd41};
    cdb[0] = '{cdb_valid: 1'b1, tag: 6'd0};
    step();
    reset = 1'b1;
    for (int w = 0; w < NR; w++) begin
      wr[w]  = '0;
      cdb[w] = '0;
    end
    #1;
    check("rst_dom port0 tag", rp[0].tag, 0);
    check("rst_dom port0 ready", rp[0].preg_ready, 1);
    check("rst_dom port1 tag", rp[1].tag, 12);
    check("rst_dom port1 ready", rp[1].preg_ready, 1);
    @(negedge clock);

    for (int i = 5; i <= 11; i++) run_vec(i);

    // Randomized traffic against the model, with occasional async resets.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        rd[p].read_en = ($urandom_range(0, 7) != 0);
        rd[p].addr    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      for (int w = 0; w < NR; w++) begin
        wr[w].write_en   = $urandom_range(0, 1);
        wr[w].addr       = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr[w].tag        = 6'($urandom_range(0, 63));
        cdb[w].cdb_valid = $urandom_range(0, 1);
        cdb[w].tag       = ($urandom_range(0, 1) != 0) ? 6'(m_tag[$urandom_range(0, 31)]) : 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      #1;
      for (int p = 0; p < NP; p++) begin
        predict(p, et, er);
        check($sformatf("rand c%0d port%0d tag", c, p), rp[p].tag, et);
        check($sformatf("rand c%0d port%0d ready", c, p), rp[p].preg_ready, er);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
